hazard_interlock: RTL and testbench
===================================

HAZARD_INTERLOCK -- requirements
Module: hazard_interlock

Interface
REQ-001 SHALL have port clock, input, 1, single system clock; all state updates on its rising edge.
REQ-002 SHALL have port reset, input, 1, synchronous active-low reset sampled on the clock rising edge.
REQ-003 SHALL have port RS_f2, input, 5, rs field of the instruction in stage 2 (decode).
REQ-004 SHALL have port RT_f2, input, 5, rt field of the instruction in stage 2.
REQ-005 SHALL have port usa_RT_f2, input, 1, stage-2 instruction reads rt.
REQ-006 SHALL have port reg_f2, input, 1, stage-2 instruction writes a register.
REQ-007 SHALL have port le_mem_f2, input, 1, stage-2 instruction is a load.
REQ-008 SHALL have port escrita_f2, input, 5, destination register of the stage-2 instruction.
REQ-009 SHALL have port desvio_f3, input, 1, branch/jump resolved taken in stage 3.
REQ-010 SHALL have port mem_ocupada, input, 1, data memory or UART not ready; pipeline frozen.
REQ-011 SHALL have port stall_pc, output, 1, hold PC.
REQ-012 SHALL have port stall_f2, output, 1, hold the stage-1/2 pipeline register.
REQ-013 SHALL have port bolha_f3, output, 1, load a bubble into the stage-2/3 pipeline register.
REQ-014 SHALL have port flush_f2, output, 1, squash the stage-1/2 pipeline register.
REQ-015 SHALL have port congela, output, 1, hold all pipeline registers from stage 3 onward.
REQ-016 SHALL have port contador_bolhas, output, 16, total bubble cycles inserted since reset.

Function
REQ-017 SHALL keep an internal stage-3 record {valid, load, dest}, loaded from reg_f2/le_mem_f2/escrita_f2 each unfrozen, unstalled cycle; loaded invalid on a bubble or flush.
REQ-018 SHALL implement FSM states RUN, STALL_LW, WAIT_MEM; outputs are Mealy, decided combinationally from state, record and inputs in the same cycle.
REQ-019 SHALL detect load-use when record.valid & record.load & record.dest != 0 & (record.dest == RS_f2 | (usa_RT_f2 & record.dest == RT_f2)).
REQ-020 SHALL, on load-use in RUN, assert stall_pc, stall_f2, bolha_f3 for exactly one cycle and move to STALL_LW.
REQ-021 SHALL, in STALL_LW, deassert all stall outputs and return to RUN; the invalidated record prevents a second stall for the same load.
REQ-022 SHALL, on desvio_f3 = 1, assert flush_f2 and bolha_f3 for one cycle and suppress the load-use stall that cycle; flush has priority over load-use.
REQ-023 SHALL, when mem_ocupada = 1 in any state, enter or stay in WAIT_MEM with stall_pc, stall_f2 and congela asserted, all other outputs 0, and the internal record held.
REQ-024 SHALL, on mem_ocupada falling, leave WAIT_MEM for RUN and evaluate hazards in that same cycle against the held record.
REQ-025 SHALL never flag a hazard on register 0, and never when the record is invalid.
REQ-026 SHALL increment contador_bolhas by 1 per cycle with bolha_f3 = 1, saturating at 16'hFFFF.
REQ-027 SHALL, when mem_ocupada and desvio_f3 coincide, apply the freeze only and honour the flush on the first unfrozen cycle, by registering desvio_f3 as a pending flag.

Reset
REQ-028 SHALL, while reset = 0 at a clock edge, set state RUN, record invalid, pending flush 0 and contador_bolhas 0.
REQ-029 SHALL drive stall_pc, stall_f2, bolha_f3, flush_f2 and congela to 0 in the cycle after reset.
REQ-030 SHALL, on reset asserted mid-STALL_LW or mid-WAIT_MEM, abandon the operation with no residual stall after release.

Structure
REQ-031 SHALL take FSM state encodings, REG_ZERO (5'd0) and the register-index width from the shared pipeline definitions include, which the forwarding unit also uses.
REQ-032 SHALL instantiate one sub-module, interlock_cmp, a 5-bit compare of a destination against rs/rt with valid and zero masking, used for the load-use check.

Verification
REQ-033 SHALL cover lw $4 then add rs=$4: one cycle stall_pc = stall_f2 = bolha_f3 = 1, then 0; contador_bolhas = 1.
REQ-034 SHALL cover lw $4 then instruction with rt=$4, usa_RT_f2 = 0: no stall; with usa_RT_f2 = 1: one stall.
REQ-035 SHALL cover lw $0 then rs=$0: no stall, contador_bolhas unchanged.
REQ-036 SHALL cover desvio_f3 = 1 coinciding with a load-use match: flush_f2 = 1, bolha_f3 = 1, stall_pc = 0.
REQ-037 SHALL cover mem_ocupada high for 3 cycles during a pending load-use: congela = 1 for 3 cycles, then exactly one bubble.
REQ-038 SHALL cover reset = 0 asserted during STALL_LW: all outputs 0 after the edge and contador_bolhas = 0.

Source files
------------

// File: rtl/hazard_interlock_pkg.sv
// Shared pipeline definitions: register index width, the zero register,
// interlock FSM encodings and the stage-3 record layout.
package hazard_interlock_pkg;

  localparam int REG_W = 5;
  localparam logic [REG_W-1:0] REG_ZERO = 5'd0;

  localparam logic [1:0] ST_RUN      = 2'd0;
  localparam logic [1:0] ST_STALL_LW = 2'd1;
  localparam logic [1:0] ST_WAIT_MEM = 2'd2;

  typedef logic [REG_W-1:0] reg_idx_t;

  typedef struct packed {
    logic     valid;
    logic     load;
    reg_idx_t dest;
  } ex_rec_t;

  localparam ex_rec_t REC_EMPTY = '{valid: 1'b0, load: 1'b0, dest: REG_ZERO};

  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

endpackage

// File: rtl/interlock_cmp.sv
// Destination-vs-source compare for the load-use check; never matches the
// zero register or an invalid destination.
module interlock_cmp
  import hazard_interlock_pkg::*;
(
  input  logic             valid,
  input  logic [REG_W-1:0] dest,
  input  logic [REG_W-1:0] rs,
  input  logic [REG_W-1:0] rt,
  input  logic             use_rt,
  output logic             hit
);

  logic dest_live;
  logic rs_match;
  logic rt_match;

  assign dest_live = valid & (dest != REG_ZERO);
  assign rs_match  = (dest == rs);
  assign rt_match  = use_rt & (dest == rt);
  assign hit       = dest_live & (rs_match | rt_match);

endmodule

// File: rtl/hazard_interlock.sv
// Pipeline hazard interlock: load-use stall, taken-branch flush and memory
// freeze, with a saturating count of inserted bubbles.
module hazard_interlock
  import hazard_interlock_pkg::*;
(
  input  logic             clock,
  input  logic             reset,
  input  logic [REG_W-1:0] RS_f2,
  input  logic [REG_W-1:0] RT_f2,
  input  logic             usa_RT_f2,
  input  logic             reg_f2,
  input  logic             le_mem_f2,
  input  logic [REG_W-1:0] escrita_f2,
  input  logic             desvio_f3,
  input  logic             mem_ocupada,
  output logic             stall_pc,
  output logic             stall_f2,
  output logic             bolha_f3,
  output logic             flush_f2,
  output logic             congela,
  output logic [15:0]      contador_bolhas
);

  logic [1:0]  state_r;
  logic [1:0]  state_nxt_s;
  ex_rec_t     rec_r;
  ex_rec_t     rec_nxt_s;
  ex_rec_t     new_rec_s;
  logic        pend_r;
  logic        pend_nxt_s;
  logic [15:0] cnt_r;
  logic        load_live_s;
  logic        hit_s;
  logic        flush_req_s;

  assign new_rec_s   = '{valid: reg_f2, load: le_mem_f2, dest: escrita_f2};
  assign load_live_s = rec_r.valid & rec_r.load;

  interlock_cmp u_cmp (
    .valid  (load_live_s),
    .dest   (rec_r.dest),
    .rs     (RS_f2),
    .rt     (RT_f2),
    .use_rt (usa_RT_f2),
    .hit    (hit_s)
  );

  // Mealy control: freeze dominates, then flush (live or deferred), then load-use.
  always_comb begin
    state_nxt_s = ST_RUN;
    rec_nxt_s   = rec_r;
    pend_nxt_s  = pend_r;
    stall_pc    = 1'b0;
    stall_f2    = 1'b0;
    bolha_f3    = 1'b0;
    flush_f2    = 1'b0;
    congela     = 1'b0;
    flush_req_s = desvio_f3 | pend_r;
    if (!reset) begin
      state_nxt_s = ST_RUN;
    end else if (mem_ocupada) begin
      stall_pc    = 1'b1;
      stall_f2    = 1'b1;
      congela     = 1'b1;
      state_nxt_s = ST_WAIT_MEM;
      pend_nxt_s  = flush_req_s;
    end else begin
      pend_nxt_s = 1'b0;
      case (state_r)
        ST_RUN, ST_WAIT_MEM: begin
          if (flush_req_s) begin
            flush_f2  = 1'b1;
            bolha_f3  = 1'b1;
            rec_nxt_s = REC_EMPTY;
          end else if (hit_s) begin
            stall_pc    = 1'b1;
            stall_f2    = 1'b1;
            bolha_f3    = 1'b1;
            rec_nxt_s   = REC_EMPTY;
            state_nxt_s = ST_STALL_LW;
          end else begin
            rec_nxt_s = new_rec_s;
          end
        end
        ST_STALL_LW: begin
          // The bubble already sits in stage 3, so the held consumer now advances.
          if (flush_req_s) begin
            flush_f2  = 1'b1;
            bolha_f3  = 1'b1;
            rec_nxt_s = REC_EMPTY;
          end else begin
            rec_nxt_s = new_rec_s;
          end
        end
        default: begin
          rec_nxt_s = REC_EMPTY;
        end
      endcase
    end
  end

  // State, stage-3 record, deferred flush and bubble counter.
  always_ff @(posedge clock) begin
    if (!reset) begin
      state_r <= ST_RUN;
      rec_r   <= REC_EMPTY;
      pend_r  <= 1'b0;
      cnt_r   <= 16'd0;
    end else begin
      state_r <= state_nxt_s;
      rec_r   <= rec_nxt_s;
      pend_r  <= pend_nxt_s;
      if (bolha_f3) begin
        cnt_r <= sat_inc16(cnt_r);
      end else begin
        cnt_r <= cnt_r;
      end
    end
  end

  assign contador_bolhas = cnt_r;

endmodule

// File: tb/tb_hazard_interlock.sv
// Bench for hazard_interlock: directed cycle table for the corner cases,
// then randomized traffic against a rule-level reference model.
module tb_hazard_interlock;

  logic        clock = 1'b0;
  logic        reset;
  logic [4:0]  RS_f2, RT_f2, escrita_f2;
  logic        usa_RT_f2, reg_f2, le_mem_f2, desvio_f3, mem_ocupada;
  logic        stall_pc, stall_f2, bolha_f3, flush_f2, congela;
  logic [15:0] contador_bolhas;

  int checks = 0;
  int failures = 0;

  always #5 clock = ~clock;

  hazard_interlock dut (
    .clock           (clock),
    .reset           (reset),
    .RS_f2           (RS_f2),
    .RT_f2           (RT_f2),
    .usa_RT_f2       (usa_RT_f2),
    .reg_f2          (reg_f2),
    .le_mem_f2       (le_mem_f2),
    .escrita_f2      (escrita_f2),
    .desvio_f3       (desvio_f3),
    .mem_ocupada     (mem_ocupada),
    .stall_pc        (stall_pc),
    .stall_f2        (stall_f2),
    .bolha_f3        (bolha_f3),
    .flush_f2        (flush_f2),
    .congela         (congela),
    .contador_bolhas (contador_bolhas)
  );

  typedef struct {
    logic        rst;
    logic [4:0]  rs, rt;
    logic        urt, wr, ld;
    logic [4:0]  dst;
    logic        dsv, mem;
    logic        spc, sf2, bol, fl, cg;
    logic [15:0] cnt;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(input logic rst, input logic [4:0] rs, input logic [4:0] rt,
                              input logic urt, input logic wr, input logic ld,
                              input logic [4:0] dst, input logic dsv, input logic mem,
                              input logic spc, input logic sf2, input logic bol,
                              input logic fl, input logic cg, input logic [15:0] cnt);
    vec_t v;
    v.rst = rst; v.rs = rs; v.rt = rt; v.urt = urt; v.wr = wr; v.ld = ld;
    v.dst = dst; v.dsv = dsv; v.mem = mem;
    v.spc = spc; v.sf2 = sf2; v.bol = bol; v.fl = fl; v.cg = cg; v.cnt = cnt;
    return v;
  endfunction

  task automatic chk(input string nm, input int cyc, input logic [15:0] got, input logic [15:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s cycle=%0d got=%h expected=%h", nm, cyc, got, exp);
    end
  endtask

  // Reference model: the stage-3 record, the deferred flush and the bubble count.
  logic m_valid, m_load, m_pend;
  logic [4:0] m_dest;
  int   m_cnt;
  logic e_spc, e_sf2, e_bol, e_fl, e_cg;

  task automatic model_eval();
    e_spc = 1'b0; e_sf2 = 1'b0; e_bol = 1'b0; e_fl = 1'b0; e_cg = 1'b0;
    if (reset) begin
      if (mem_ocupada) begin
        e_spc = 1'b1; e_sf2 = 1'b1; e_cg = 1'b1;
      end else if (desvio_f3 || m_pend) begin
        e_fl = 1'b1; e_bol = 1'b1;
      end else if (m_valid && m_load && m_dest != 5'd0 &&
                   (m_dest == RS_f2 || (usa_RT_f2 && m_dest == RT_f2))) begin
        e_spc = 1'b1; e_sf2 = 1'b1; e_bol = 1'b1;
      end
    end
  endtask

  task automatic model_advance();
    if (!reset) begin
      m_valid = 1'b0; m_load = 1'b0; m_dest = 5'd0; m_pend = 1'b0; m_cnt = 0;
    end else begin
      if (e_bol && m_cnt < 65535) m_cnt = m_cnt + 1;
      if (mem_ocupada) begin
        m_pend = m_pend | desvio_f3;
      end else if (e_bol) begin
        m_valid = 1'b0; m_pend = 1'b0;
      end else begin
        m_valid = reg_f2; m_load = le_mem_f2; m_dest = escrita_f2; m_pend = 1'b0;
      end
    end
  endtask

  task automatic drive(input vec_t v);
    reset = v.rst; RS_f2 = v.rs; RT_f2 = v.rt; usa_RT_f2 = v.urt;
    reg_f2 = v.wr; le_mem_f2 = v.ld; escrita_f2 = v.dst;
    desvio_f3 = v.dsv; mem_ocupada = v.mem;
  endtask

  initial begin
    vec_t q;
    q = mk(1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 16'd0);
    drive(q);
    repeat (2) @(posedge clock);
    #1;

    //        rst   rs     rt     urt   wr    ld    dst     dsv   mem   spc   sf2   bol   fl    cg    cnt
    vecs.push_back(mk(1'b1,5'd0, 5'd0, 1'b0,1'b0,1'b0,5'd0, 1'b0,1'b0, 1'b0,1'b0,1'b0,1'b0,1'b0,16'd0));
    // lw $4 then add rs=$4
    vecs.push_back(mk(1'b1,5'd1, 5'd2, 1'b1,1'b1,1'b1,5'd4, 1'b0,1'b0, 1'b0,1'b0,1'b0,1'b0,1'b0,16'd0));
    vecs.push_back(mk(1'b1,5'd4, 5'd5, 1'b1,1'b1,1'b0,5'd6, 1'b0,1'b0, 1'b1,1'b1,1'b1,1'b0,1'b0,16'd0));
    vecs.push_back(mk(1'b1,5'd4, 5'd5, 1'b1,1'b1,1'b0,5'd6, 1'b0,1'b0, 1'b0,1'b0,1'b0,1'b0,1'b0,16'd1));
    vecs.push_back(mk(1'b1,5'd0, 5'd0, 1'b0,1'b0,1'b0,5'd0, 1'b0,1'b0, 1'b0,1'b0,1'b0,1'b0,1'b0,16'd1));
    // rt match ignored unless usa_RT_f2
    vecs.push_back(mk(1'b1,5'd0, 5'd0, 1'b0,1'b1,1'b1,5'd4, 1'b0,1'b0, 1'b0,1'b0,1'b0,1'b0,1'b0,16'd1));
    vecs.push_back(mk(1'b1,5'd3, 5'd4, 1'b0,1'b1,1'b0,5'd7, 1'b0,1'b0, 1'b0,1'b0,1'b0,1'b0,1'b0,16'd1));
    vecs.push_back(mk(1'b1,5'd0, 5'd0, 1'b0,1'b1,1'b1,5'd4, 1'b0,1'b0, 1'b0,1'b0,1'b0,1'b0,1'b0,16'd1));
    vecs.push_back(mk(1'b1,5'd3, 5'd4, 1'b1,1'b1,1'b0,5'd7, 1'b0,1'b0, 1'b1,1'b1,1'b1,1'b0,1'b0,16'd1));
    vecs.push_back(mk(1'b1,5'd3, 5'd4, 1'b1,1'b1,1'b0,5'd7, 1'b0,1'b0, 1'b0,1'b0,1'b0,1'b0,1'b0,16'd2));
    // lw $0 never interlocks
    vecs.push_back(mk(1'b1,5'd0, 5'd0, 1'b0,1'b1,1'b1,5'd0, 1'b0,1'b0, 1'b0,1'b0,1'b0,1'b0,1'b0,16'd2));
    vecs.push_back(mk(1'b1,5'd0, 5'd0, 1'b1,1'b1,1'b0,5'd8, 1'b0,1'b0, 1'b0,1'b0,1'b0,1'b0,1'b0,16'd2));
    // branch coinciding with load-use: flush wins
    vecs.push_back(mk(1'b1,5'd1, 5'd0, 1'b0,1'b1,1'b1,5'd5, 1'b0,1'b0, 1'b0,1'b0,1'b0,1'b0,1'b0,16'd2));
    vecs.push_back(mk(1'b1,5'd5, 5'd0, 1'b0,1'b1,1'b0,5'd9, 1'b1,1'b0, 1'b0,1'b0,1'b1,1'b1,1'b0,16'd2));
    vecs.push_back(mk(1'b1,5'd0, 5'd0, 1'b0,1'b0,1'b0,5'd0, 1'b0,1'b0, 1'b0,1'b0,1'b0,1'b0,1'b0,16'd3));
    // memory busy 3 cycles over a pending load-use, then one bubble
    vecs.push_back(mk(1'b1,5'd0, 5'd0, 1'b0,1'b1,1'b1,5'd6, 1'b0,1'b0, 1'b0,1'b0,1'b0,1'b0,1'b0,16'd3));
    vecs.push_back(mk(1'b1,5'd6, 5'd0, 1'b0,1'b1,1'b0,5'd10,1'b0,1'b1, 1'b1,1'b1,1'b0,1'b0,1'b1,16'd3));
    vecs.push_back(mk(1'b1,5'd6, 5'd0, 1'b0,1'b1,1'b0,5'd10,1'b0,1'b1, 1'b1,1'b1,1'b0,1'b0,1'b1,16'd3));
    vecs.push_back(mk(1'b1,5'd6, 5'd0, 1'b0,1'b1,1'b0,5'd10,1'b0,1'b1, 1'b1,1'b1,1'b0,1'b0,1'b1,16'd3));
    vecs.push_back(mk(1'b1,5'd6, 5'd0, 1'b0,1'b1,1'b0,5'd10,1'b0,1'b0, 1'b1,1'b1,1'b1,1'b0,1'b0,16'd3));
    vecs.push_back(mk(1'b1,5'd6, 5'd0, 1'b0,1'b1,1'b0,5'd10,1'b0,1'b0, 1'b0,1'b0,1'b0,1'b0,1'b0,16'd4));
    // branch during freeze is deferred to the first unfrozen cycle
    vecs.push_back(mk(1'b1,5'd0, 5'd0, 1'b0,1'b0,1'b0,5'd0, 1'b1,1'b1, 1'b1,1'b1,1'b0,1'b0,1'b1,16'd4));
    vecs.push_back(mk(1'b1,5'd0, 5'd0, 1'b0,1'b0,1'b0,5'd0, 1'b0,1'b0, 1'b0,1'b0,1'b1,1'b1,1'b0,16'd4));
    vecs.push_back(mk(1'b1,5'd0, 5'd0, 1'b0,1'b0,1'b0,5'd0, 1'b0,1'b0, 1'b0,1'b0,1'b0,1'b0,1'b0,16'd5));
    // reset in the middle of STALL_LW
    vecs.push_back(mk(1'b1,5'd0, 5'd0, 1'b0,1'b1,1'b1,5'd4, 1'b0,1'b0, 1'b0,1'b0,1'b0,1'b0,1'b0,16'd5));
    vecs.push_back(mk(1'b1,5'd4, 5'd0, 1'b0,1'b1,1'b0,5'd11,1'b0,1'b0, 1'b1,1'b1,1'b1,1'b0,1'b0,16'd5));
    vecs.push_back(mk(1'b0,5'd4, 5'd0, 1'b0,1'b1,1'b0,5'd11,1'b0,1'b0, 1'b0,1'b0,1'b0,1'b0,1'b0,16'd6));
    vecs.push_back(mk(1'b1,5'd4, 5'd0, 1'b0,1'b1,1'b0,5'd11,1'b0,1'b0, 1'b0,1'b0,1'b0,1'b0,1'b0,16'd0));
    vecs.push_back(mk(1'b1,5'd0, 5'd0, 1'b0,1'b0,1'b0,5'd0, 1'b0,1'b0, 1'b0,1'b0,1'b0,1'b0,1'b0,16'd0));

    for (int i = 0; i < vecs.size(); i++) begin
      drive(vecs[i]);
      @(negedge clock);
      chk("vec_stall_pc", i, {15'd0, stall_pc}, {15'd0, vecs[i].spc});
      chk("vec_stall_f2", i, {15'd0, stall_f2}, {15'd0, vecs[i].sf2});
      chk("vec_bolha_f3", i, {15'd0, bolha_f3}, {15'd0, vecs[i].bol});
      chk("vec_flush_f2", i, {15'd0, flush_f2}, {15'd0, vecs[i].fl});
      chk("vec_congela", i, {15'd0, congela}, {15'd0, vecs[i].cg});
      chk("vec_contador", i, contador_bolhas, vecs[i].cnt);
      @(posedge clock);
      #1;
    end

    m_valid = 1'b0; m_load = 1'b0; m_dest = 5'd0; m_pend = 1'b0; m_cnt = 0;
    for (int c = 0; c < 3000; c++) begin
      reset       = (c < 2) ? 1'b0 : ($urandom_range(0, 199) != 0);
      RS_f2       = 5'($urandom_range(0, 3));
      RT_f2       = 5'($urandom_range(0, 3));
      escrita_f2  = 5'($urandom_range(0, 3));
      usa_RT_f2   = 1'($urandom_range(0, 1));
      reg_f2      = ($urandom_range(0, 3) != 0);
      le_mem_f2   = 1'($urandom_range(0, 1));
      desvio_f3   = ($urandom_range(0, 9) == 0);
      mem_ocupada = ($urandom_range(0, 4) == 0);
      @(negedge clock);
      model_eval();
      if (c >= 1) begin
        chk("rnd_stall_pc", c, {15'd0, stall_pc}, {15'd0, e_spc});
        chk("rnd_stall_f2", c, {15'd0, stall_f2}, {15'd0, e_sf2});
        chk("rnd_bolha_f3", c, {15'd0, bolha_f3}, {15'd0, e_bol});
        chk("rnd_flush_f2", c, {15'd0, flush_f2}, {15'd0, e_fl});
        chk("rnd_congela", c, {15'd0, congela}, {15'd0, e_cg});
        chk("rnd_contador", c, contador_bolhas, 16'(m_cnt));
      end
      @(posedge clock);
      model_advance();
      #1;
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
